// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation pipeline: RV opcodes,
// immediate format codes and the decode result record.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } fmt_e;

    // Every RV immediate fits a signed 32-bit value; it is widened to XLEN at the port.
    typedef struct packed {
        logic [31:0] imm32;
        fmt_e        fmt;
        logic        illegal;
    } dec_res_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode of one RV instruction word into a
// sign/zero-extended XLEN immediate, its format code and an illegal flag.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam bit IS_RV64 = (XLEN == 32'd64);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       load_ok_s;
    logic       shift_ok_s;
    dec_res_t   res_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];

    // Legal load widths; LD and LWU only exist on RV64
    always_comb begin
        load_ok_s = 1'b0;
        case (funct3_s)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok_s = 1'b1;
            3'b011, 3'b110:                         load_ok_s = IS_RV64;
            default:                                load_ok_s = 1'b0;
        endcase
    end

    // Shift-immediate upper bits; RV64 frees instr[25] for a 6-bit shamt
    always_comb begin
        shift_ok_s = 1'b1;
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
            if (IS_RV64) begin
                shift_ok_s = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
            end else begin
                shift_ok_s = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
            end
        end else begin
            shift_ok_s = 1'b1;
        end
    end

    // Opcode-driven immediate assembly
    always_comb begin
        res_s.imm32   = 32'd0;
        res_s.fmt     = FMT_R;
        res_s.illegal = 1'b0;
        case (opcode_s)
            OPC_LOAD: begin
                res_s.imm32   = {{20{instr[31]}}, instr[31:20]};
                res_s.fmt     = FMT_I;
                res_s.illegal = !load_ok_s;
            end
            OPC_OP_IMM: begin
                res_s.imm32   = {{20{instr[31]}}, instr[31:20]};
                res_s.fmt     = FMT_I;
                res_s.illegal = !shift_ok_s;
            end
            OPC_JALR: begin
                res_s.imm32 = {{20{instr[31]}}, instr[31:20]};
                res_s.fmt   = FMT_I;
            end
            OPC_STORE: begin
                res_s.imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                res_s.fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                res_s.imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                res_s.fmt   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                res_s.imm32 = {instr[31:12], 12'h000};
                res_s.fmt   = FMT_U;
            end
            OPC_JAL: begin
                res_s.imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                res_s.fmt   = FMT_J;
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK (funct3 000) carry no immediate and report as R with imm 0
                if (funct3_s != 3'b000) begin
                    res_s.imm32 = {27'd0, instr[19:15]};
                    res_s.fmt   = FMT_Z;
                end else begin
                    res_s.imm32 = 32'd0;
                    res_s.fmt   = FMT_R;
                end
            end
            OPC_OP: begin
                res_s.imm32 = 32'd0;
                res_s.fmt   = FMT_R;
            end
            default: begin
                res_s.imm32   = 32'd0;
                res_s.fmt     = FMT_R;
                res_s.illegal = 1'b1;
            end
        endcase
    end

    assign imm     = XLEN'($signed(res_s.imm32));
    assign fmt     = res_s.fmt;
    assign illegal = res_s.illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate decoder followed by a DEPTH-entry result queue with a fully
// registered head (outputs read zero while the queue is empty).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm_s;
    fmt_e            dec_fmt_s;
    logic            dec_illegal_s;
    entry_t          new_entry_s;

    entry_t          mem_r [DEPTH];
    entry_t          head_r;
    entry_t          head_nx_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_nx_s;
    logic [PW-1:0]   rd_ptr_nx_s;
    logic [CW-1:0]   count_nx_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            push_s;
    logic            pop_s;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr   (in_instr),
        .imm     (dec_imm_s),
        .fmt     (dec_fmt_s),
        .illegal (dec_illegal_s)
    );

    assign new_entry_s = '{imm: dec_imm_s, fmt: dec_fmt_s, illegal: dec_illegal_s};

    // in_ready_r is already false when full, so a same-cycle pop never frees a push slot
    assign push_s = in_valid && in_ready_r && !flush;
    assign pop_s  = out_valid_r && out_ready && !flush;

    // Next-state pointers and occupancy; flush wins over push and pop
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        count_nx_s  = count_r;
        if (flush) begin
            wr_ptr_nx_s = {PW{1'b0}};
            rd_ptr_nx_s = {PW{1'b0}};
            count_nx_s  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nx_s = wr_ptr_r + PW'(1'b1);
            end else begin
                wr_ptr_nx_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nx_s = rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nx_s = count_r + CW'(1'b1);
                2'b01:   count_nx_s = count_r - CW'(1'b1);
                default: count_nx_s = count_r;
            endcase
        end
    end

    // Next head: the freshly decoded word bypasses storage when it lands at the read slot
    always_comb begin
        head_nx_s = '0;
        if (count_nx_s == {CW{1'b0}}) begin
            head_nx_s = '0;
        end else if (push_s && (rd_ptr_nx_s == wr_ptr_r)) begin
            head_nx_s = new_entry_s;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // Queue control state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= '0;
        end else begin
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            count_r     <= count_nx_s;
            in_ready_r  <= (count_nx_s != CW'(DEPTH));
            out_valid_r <= (count_nx_s != {CW{1'b0}});
            head_r      <= head_nx_s;
        end
    end

    // Storage array; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_imm     = head_r.imm;
    assign out_fmt     = head_r.fmt;
    assign out_illegal = head_r.illegal;

endmodule
